// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : dmem_pkg                                                  |
// | Purpose  : Shared types, transfer-size constants and request-check   |
// |            helpers for the dmem_responder load/store responder.      |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  // Legal size, naturally aligned, and fully inside [0, depth).
  // The end address is formed at 65 bits so a request near 2^64 cannot
  // wrap around into range.
  function automatic logic size_ok(input logic [3:0]  size,
                                   input logic [63:0] addr,
                                   input logic [63:0] depth);
    logic        legal;
    logic        aligned;
    logic [64:0] end_addr;
    legal    = (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    aligned  = ((addr & {60'd0, size - 4'd1}) == 64'd0);
    end_addr = {1'b0, addr} + {61'd0, size};
    return legal && aligned && (end_addr <= {1'b0, depth});
  endfunction

  // One bit per byte lane covered by a transfer of the given size,
  // before shifting to the lane offset.
  function automatic logic [7:0] lane_mask(input logic [3:0] size);
    logic [7:0] m;
    case (size)
      SZ_D:    m = 8'hFF;
      SZ_W:    m = 8'h0F;
      SZ_H:    m = 8'h03;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : byte_ram                                                  |
// | Purpose  : DEPTH bytes of storage organised as 8-byte words, with    |
// |            one write port (per-byte enable) and one synchronous read |
// |            port. Contents are never reset.                           |
// | Ports    : clk      - rising-edge clock                              |
// |            wr_en    - write strobe                                   |
// |            wr_be    - per-byte lane enables                          |
// |            wr_addr  - word address for the write                     |
// |            wr_data  - 8-byte write data, lane k = bits [8k+7:8k]     |
// |            rd_en    - read strobe; rd_data updates on the next edge  |
// |            rd_addr  - word address for the read                      |
// |            rd_data  - registered read data, held until next rd_en    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module byte_ram #(
  parameter int DEPTH = 1024,
  parameter int WA    = (DEPTH > 8) ? $clog2(DEPTH / 8) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [7:0]    wr_be,
  input  logic [WA-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic          rd_en,
  input  logic [WA-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  localparam int WORDS = DEPTH / 8;

  // One independent byte-wide array per lane keeps the byte enables trivial.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_be[k]) begin
        mem[wr_addr] <= wr_data[8*k +: 8];
      end
      if (rd_en) begin
        rd_q <= mem[rd_addr];
      end
    end

    assign rd_data[8*k +: 8] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder                                            |
// | Purpose  : Memory-side responder for the CPU load/store port. Takes  |
// |            one request per handshake, waits WAIT_CYCLES, then returns|
// |            load data or a store acknowledge. Little-endian, 1/2/4/8  |
// |            byte transfers, range/alignment/size checking.            |
// | Ports    : clk, reset (async, active-high)                           |
// |            req_valid/req_ready  - request handshake                  |
// |            req_write, req_addr, req_size, req_wdata - request fields  |
// |            rsp_valid/rsp_ready  - response handshake                 |
// |            rsp_rdata            - zero-extended load data            |
// |            rsp_err              - illegal size, misaligned or range  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             WA        = (DEPTH > 8) ? AW - 3 : 1;
  localparam int             CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  WAIT_INIT = CW'(WAIT_CYCLES);
  localparam logic [63:0]    DEPTH_64  = 64'(DEPTH);

  dmem_state_t   state, next_state;
  logic          ready_q;
  logic [CW-1:0] wait_cnt;

  logic          lat_write;
  logic          lat_err;
  logic [AW-1:0] lat_addr;
  logic [3:0]    lat_size;
  logic [63:0]   lat_wdata;

  logic          accept;
  logic          req_err;
  logic          op_go;
  logic          op_write;
  logic          op_err;
  logic [AW-1:0] op_addr;
  logic [3:0]    op_size;
  logic [63:0]   op_wdata;

  logic          ram_we;
  logic          ram_re;
  logic [7:0]    ram_be;
  logic [WA-1:0] ram_word;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  logic [63:0]   rd_shifted;
  logic [63:0]   rd_mask;
  logic [7:0]    rd_lanes;

  // ready_q tracks "next state is IDLE", so it is only ever high in IDLE
  // and is held low during reset as required.
  assign accept  = req_valid && ready_q && (state == S_IDLE);
  assign req_err = !size_ok(req_size, req_addr, DEPTH_64);

  // ------------------------------------------------------------------
  // FSM next-state and memory-operation select. The memory operation
  // fires on the cycle the FSM moves into RESP; with no wait cycles that
  // is the accept cycle itself, so the fields come straight from req_*.
  // ------------------------------------------------------------------
  always_comb begin
    next_state = state;
    op_go      = 1'b0;
    op_write   = lat_write;
    op_err     = lat_err;
    op_addr    = lat_addr;
    op_size    = lat_size;
    op_wdata   = lat_wdata;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            op_go      = 1'b1;
            op_write   = req_write;
            op_err     = req_err;
            op_addr    = req_addr[AW-1:0];
            op_size    = req_size;
            op_wdata   = req_wdata;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          next_state = S_RESP;
          op_go      = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == S_IDLE);
    end
  end

  // Request latch and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_err   <= req_err;
      lat_addr  <= req_addr[AW-1:0];
      lat_size  <= req_size;
      lat_wdata <= req_wdata;
      wait_cnt  <= WAIT_INIT;
    end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
      wait_cnt  <= wait_cnt - CW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Lane alignment. Legal requests are naturally aligned, so every byte
  // of a transfer lies in the same 8-byte word; the low three address
  // bits select the starting lane.
  // ------------------------------------------------------------------
  assign ram_we    = op_go && op_write && !op_err;
  assign ram_re    = op_go && !op_write && !op_err;
  assign ram_be    = lane_mask(op_size) << op_addr[2:0];
  assign ram_wdata = op_wdata << {op_addr[2:0], 3'b000};

  if (DEPTH > 8) begin : g_word_addr
    assign ram_word = op_addr[AW-1:3];
  end else begin : g_single_word
    assign ram_word = 1'b0;
  end

  byte_ram #(
    .DEPTH (DEPTH),
    .WA    (WA)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_be   (ram_be),
    .wr_addr (ram_word),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_word),
    .rd_data (ram_rdata)
  );

  // The RAM read register only changes on ram_re, which cannot occur in
  // RESP, so the response data stays stable under backpressure.
  assign rd_shifted = ram_rdata >> {lat_addr[2:0], 3'b000};
  assign rd_lanes   = lane_mask(lat_size);

  always_comb begin
    rd_mask = '0;
    for (int k = 0; k < 8; k++) begin
      rd_mask[8*k +: 8] = {8{rd_lanes[k]}};
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = (state == S_RESP) && lat_err;
  assign rsp_rdata = ((state == S_RESP) && !lat_write && !lat_err) ? (rd_shifted & rd_mask) : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                         |
// | Purpose  : Self-checking bench for dmem_responder: table of directed |
// |            load/store vectors plus hand-written backpressure and     |
// |            mid-transaction reset sequences.                          |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int DEPTH       = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int EXP_LAT     = WAIT_CYCLES + 1;
  localparam int NVEC        = 20;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr  = 64'd0;
  logic [3:0]  req_size  = 4'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [3:0]  s;
    logic [63:0] d;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Starts and ends on a falling edge. lat = rising edges after the accept
  // edge until rsp_valid is seen high.
  task automatic run_txn(input logic w, input logic [63:0] a, input logic [3:0] s,
                         input logic [63:0] d, output logic [63:0] rd,
                         output logic er, output int lat, output bit ok);
    int guard;
    ok  = 1'b0;
    rd  = 64'd0;
    er  = 1'b0;
    lat = 0;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) return;
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ok = 1'b1;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    int          guard;

    vecs[0]  = '{1'b1, 64'h10,                  4'd8, 64'h0123456789ABCDEF, 64'h0,                1'b0};
    vecs[1]  = '{1'b0, 64'h10,                  4'd8, 64'h0,                64'h0123456789ABCDEF, 1'b0};
    vecs[2]  = '{1'b1, 64'h12,                  4'd1, 64'hFFFFFFFFFFFFFFAA, 64'h0,                1'b0};
    vecs[3]  = '{1'b0, 64'h10,                  4'd8, 64'h0,                64'h0123456789AACDEF, 1'b0};
    vecs[4]  = '{1'b0, 64'h12,                  4'd2, 64'h0,                64'h00000000000089AA, 1'b0};
    vecs[5]  = '{1'b0, 64'h11,                  4'd4, 64'h0,                64'h0,                1'b1};
    vecs[6]  = '{1'b1, 64'd1016,                4'd8, 64'hCAFEBABEDEADBEEF, 64'h0,                1'b0};
    vecs[7]  = '{1'b1, 64'd1020,                4'd8, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1};
    vecs[8]  = '{1'b1, 64'd1024,                4'd8, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1};
    vecs[9]  = '{1'b1, 64'hFFFFFFFFFFFFFFF8,    4'd8, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1};
    vecs[10] = '{1'b1, 64'h20,                  4'd3, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1};
    vecs[11] = '{1'b0, 64'h10,                  4'd0, 64'h0,                64'h0,                1'b1};
    vecs[12] = '{1'b0, 64'd1016,                4'd8, 64'h0,                64'hCAFEBABEDEADBEEF, 1'b0};
    vecs[13] = '{1'b0, 64'd1023,                4'd1, 64'h0,                64'h00000000000000CA, 1'b0};
    vecs[14] = '{1'b0, 64'd1020,                4'd4, 64'h0,                64'h00000000CAFEBABE, 1'b0};
    vecs[15] = '{1'b1, 64'h16,                  4'd2, 64'h0000000012345A5A, 64'h0,                1'b0};
    vecs[16] = '{1'b0, 64'h10,                  4'd8, 64'h0,                64'h5A5A456789AACDEF, 1'b0};
    vecs[17] = '{1'b0, 64'h14,                  4'd4, 64'h0,                64'h000000005A5A4567, 1'b0};
    vecs[18] = '{1'b1, 64'h20,                  4'd8, 64'h1122334455667788, 64'h0,                1'b0};
    vecs[19] = '{1'b0, 64'd1022,                4'd2, 64'h0,                64'h000000000000CAFE, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_rdata", rsp_rdata, 64'd0);
    check("reset rsp_err",   64'(rsp_err),   64'd0);
    reset = 1'b0;
    #1;
    check("req_ready before first edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("req_ready after release", 64'(req_ready), 64'd1);
    check("rsp_valid after release", 64'(rsp_valid), 64'd0);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, rd, er, lat, ok);
      if (!ok) begin
        timeout($sformatf("vec%0d", i));
      end else begin
        check($sformatf("vec%0d rdata", i),   rd,       vecs[i].exp_rdata);
        check($sformatf("vec%0d err", i),     64'(er),  64'(vecs[i].exp_err));
        check($sformatf("vec%0d latency", i), 64'(lat), 64'(EXP_LAT));
      end
    end

    // Backpressure: response held for 5 cycles while a new request waits
    req_write = 1'b0;
    req_addr  = 64'h10;
    req_size  = 4'd8;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!rsp_valid) begin
      timeout("backpressure rsp");
    end else begin
      req_write = 1'b1;
      req_wdata = 64'h0;
      req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check($sformatf("bp%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
        check($sformatf("bp%0d rdata", c),     rsp_rdata,      64'h5A5A456789AACDEF);
        check($sformatf("bp%0d err", c),       64'(rsp_err),   64'd0);
        check($sformatf("bp%0d req_ready", c), 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp rsp_valid dropped", 64'(rsp_valid), 64'd0);
      check("bp req_ready back",    64'(req_ready), 64'd1);
    end
    run_txn(1'b0, 64'h10, 4'd8, 64'h0, rd, er, lat, ok);
    if (!ok) timeout("bp reload");
    else check("bp store ignored", rd, 64'h5A5A456789AACDEF);

    // Reset pulsed during WAIT of a store: the store must be dropped
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_size  = 4'd8;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid reset req_ready", 64'(req_ready), 64'd0);
    check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("post reset req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("post reset no rsp", 64'(rsp_valid), 64'd0);
    check("post reset idle",   64'(req_ready), 64'd1);
    run_txn(1'b0, 64'h20, 4'd8, 64'h0, rd, er, lat, ok);
    if (!ok) begin
      timeout("post reset load");
    end else begin
      check("aborted store dropped", rd,       64'h1122334455667788);
      check("post reset load err",   64'(er),  64'd0);
      check("post reset latency",    64'(lat), 64'(EXP_LAT));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
